// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the WISC pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned RegW = 3;
  localparam logic [15:0] NopOpcode = 16'h0800;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StRawWait = 3'd1,
    StMemWait = 3'd2,
    StDrain   = 3'd3,
    StHalted  = 3'd4
  } state_e;

endpackage

// File: rtl/wr_scoreboard.sv
// Shift chain of in-flight register writes; entry0 is EX, the last entry is the oldest writer.
module wr_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hold,
  input  logic            i_kill0,
  input  logic            i_load_valid,
  input  logic [RegW-1:0] i_load_reg,
  input  logic [RegW-1:0] i_cmp_a,
  input  logic [RegW-1:0] i_cmp_b,
  output logic            o_hit_a,
  output logic            o_hit_b
);

  logic [Depth-1:0] r_vld;
  logic [RegW-1:0]  r_reg [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_reg[i] <= '0;
      end
    end else if (!i_hold) begin
      r_vld[0] <= i_load_valid & ~i_kill0;
      r_reg[0] <= i_load_reg;
      for (int i = 1; i < int'(Depth); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_reg[i] <= r_reg[i-1];
      end
    end
  end

  always_comb begin
    o_hit_a = 1'b0;
    o_hit_b = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (r_vld[i] && (r_reg[i] == i_cmp_a)) o_hit_a = 1'b1;
      if (r_vld[i] && (r_reg[i] == i_cmp_b)) o_hit_b = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: RAW detection, stall/bubble/flush/freeze arbitration and halt drain.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH  = 2,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_rd1_use,
  input  logic            id_rd2_use,
  input  logic [RegW-1:0] id_rd1,
  input  logic [RegW-1:0] id_rd2,
  input  logic            id_wr_en,
  input  logic [RegW-1:0] id_wr_reg,
  input  logic            id_halt,
  input  logic            br_taken,
  input  logic            imem_stall,
  input  logic            dmem_stall,
  output logic            stall_if,
  output logic            bubble_id,
  output logic            freeze,
  output logic            flush,
  output logic            halted,
  output logic [2:0]      state
);

  localparam int unsigned CntW = $clog2(DRAIN_CYC + 1);

  state_e          r_state;
  state_e          r_resume;
  logic [CntW-1:0] r_cnt;

  logic   w_hit1;
  logic   w_hit2;
  logic   w_raw;
  logic   w_halt_go;
  state_e w_eff;
  logic   w_stall_if;
  logic   w_bubble;
  logic   w_freeze;
  logic   w_flush;

  wr_scoreboard #(
    .Depth (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_hold       (w_freeze),
    .i_kill0      (w_flush),
    .i_load_valid (id_valid & id_wr_en & ~w_bubble),
    .i_load_reg   (id_wr_reg),
    .i_cmp_a      (id_rd1),
    .i_cmp_b      (id_rd2),
    .o_hit_a      (w_hit1),
    .o_hit_b      (w_hit2)
  );

  assign w_raw     = id_valid & ((id_rd1_use & w_hit1) | (id_rd2_use & w_hit2));
  assign w_halt_go = id_halt & id_valid & ~w_raw & ~br_taken;
  // On release from a memory stall the pipe behaves as the interrupted state.
  assign w_eff     = (r_state == StMemWait) ? r_resume : r_state;

  always_comb begin
    w_stall_if = 1'b0;
    w_bubble   = 1'b0;
    w_freeze   = 1'b0;
    w_flush    = 1'b0;
    if (r_state == StHalted) begin
      w_stall_if = 1'b1;
      w_freeze   = 1'b1;
    end else if (dmem_stall) begin
      w_freeze = 1'b1;
    end else if (br_taken) begin
      w_flush = 1'b1;
    end else begin
      if (w_raw || imem_stall) begin
        w_stall_if = 1'b1;
        w_bubble   = 1'b1;
      end
      if (w_eff == StDrain) w_stall_if = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StRun;
      r_resume <= StRun;
      r_cnt    <= '0;
    end else if (r_state == StHalted) begin
      r_state <= StHalted;
    end else if (dmem_stall) begin
      r_state  <= StMemWait;
      r_resume <= (w_eff == StDrain) ? StDrain : StRun;
    end else if (w_eff == StDrain) begin
      // A taken branch means the halt was fetched down the wrong path.
      if (br_taken) begin
        r_state <= StRun;
        r_cnt   <= '0;
      end else if (r_cnt == CntW'(1)) begin
        r_state <= StHalted;
        r_cnt   <= '0;
      end else begin
        r_state <= StDrain;
        r_cnt   <= r_cnt - 1'b1;
      end
    end else begin
      if (br_taken) begin
        r_state <= StRun;
      end else if (w_raw) begin
        r_state <= StRawWait;
      end else if (w_halt_go) begin
        r_state <= StDrain;
        r_cnt   <= CntW'(DRAIN_CYC);
      end else begin
        r_state <= StRun;
      end
    end
  end

  assign stall_if  = w_stall_if & ~rst;
  assign bubble_id = w_bubble & ~rst;
  assign freeze    = w_freeze & ~rst;
  assign flush     = w_flush & ~rst;
  assign halted    = (r_state == StHalted) & ~rst;
  assign state     = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random stimulus vs a model.
`timescale 1ns / 100ps
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rd1_use, id_rd2_use, id_wr_en, id_halt;
  logic [2:0] id_rd1, id_rd2, id_wr_reg;
  logic       br_taken, imem_stall, dmem_stall;
  logic       stall_if, bubble_id, freeze, flush, halted;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_ctrl #(
    .SB_DEPTH  (2),
    .DRAIN_CYC (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rd1_use (id_rd1_use),
    .id_rd2_use (id_rd2_use),
    .id_rd1     (id_rd1),
    .id_rd2     (id_rd2),
    .id_wr_en   (id_wr_en),
    .id_wr_reg  (id_wr_reg),
    .id_halt    (id_halt),
    .br_taken   (br_taken),
    .imem_stall (imem_stall),
    .dmem_stall (dmem_stall),
    .stall_if   (stall_if),
    .bubble_id  (bubble_id),
    .freeze     (freeze),
    .flush      (flush),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // {stall_if, bubble_id, freeze, flush, halted, state}
  function automatic logic [7:0] obs();
    return {stall_if, bubble_id, freeze, flush, halted, state};
  endfunction

  function automatic logic [7:0] ex(input bit s, input bit b, input bit f, input bit fl,
                                    input bit h, input logic [2:0] st);
    return {s, b, f, fl, h, st};
  endfunction

  task automatic drive(input bit v, input bit u1, input bit u2, input logic [2:0] r1,
                       input logic [2:0] r2, input bit we, input logic [2:0] wr, input bit h,
                       input bit br, input bit im, input bit dm);
    id_valid = v; id_rd1_use = u1; id_rd2_use = u2; id_rd1 = r1; id_rd2 = r2;
    id_wr_en = we; id_wr_reg = wr; id_halt = h;
    br_taken = br; imem_stall = im; dmem_stall = dm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic drive_rand();
    drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
          3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
          3'($urandom_range(7, 0)), $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0,
          $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0);
  endtask

  // ---------------- reference model ----------------
  localparam int MRun = 0, MRawWait = 1, MMem = 2, MDrain = 3, MHalt = 4;
  int   m_mode, m_resume, m_left;
  int   m_pend[$];  // destination regs of writers past ID, newest first; -1 = empty slot
  bit   e_raw, e_stall, e_bub, e_frz, e_fl, e_hlt;
  logic [7:0] e_vec;

  task automatic model_reset();
    m_mode = MRun; m_resume = MRun; m_left = 0;
    m_pend = '{-1, -1};
  endtask

  task automatic model_eval();
    bit h1, h2;
    int eff;
    h1 = 0; h2 = 0;
    foreach (m_pend[k]) begin
      if (m_pend[k] == int'(id_rd1)) h1 = 1;
      if (m_pend[k] == int'(id_rd2)) h2 = 1;
    end
    e_raw = id_valid && ((id_rd1_use && h1) || (id_rd2_use && h2));
    eff = (m_mode == MMem) ? m_resume : m_mode;
    e_stall = 0; e_bub = 0; e_frz = 0; e_fl = 0; e_hlt = (m_mode == MHalt);
    if (m_mode == MHalt) begin
      e_stall = 1; e_frz = 1;
    end else if (dmem_stall) begin
      e_frz = 1;
    end else if (br_taken) begin
      e_fl = 1;
    end else begin
      e_bub   = e_raw || imem_stall;
      e_stall = e_bub || (eff == MDrain);
    end
    e_vec = ex(e_stall, e_bub, e_frz, e_fl, e_hlt, 3'(m_mode));
  endtask

  task automatic model_step();
    int eff;
    eff = (m_mode == MMem) ? m_resume : m_mode;
    if (!e_frz) begin
      m_pend.push_front((id_valid && id_wr_en && !e_bub && !e_fl) ? int'(id_wr_reg) : -1);
      void'(m_pend.pop_back());
    end
    if (m_mode == MHalt) return;
    if (dmem_stall) begin
      m_resume = (eff == MDrain) ? MDrain : MRun;
      m_mode   = MMem;
    end else if (eff == MDrain) begin
      if (br_taken) begin m_mode = MRun; m_left = 0; end
      else if (m_left == 1) m_mode = MHalt;
      else begin m_left--; m_mode = MDrain; end
    end else if (br_taken) m_mode = MRun;
    else if (e_raw) m_mode = MRawWait;
    else if (id_halt && id_valid) begin m_mode = MDrain; m_left = 3; end
    else m_mode = MRun;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    n_checks++;
    if (obs() !== 8'h00) begin
      n_errors++; $display("FAIL reset_idle: got %b want %b", obs(), 8'h00);
    end
    br_taken = 1'b1; dmem_stall = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 8'h00) begin
      n_errors++; $display("FAIL reset_gated: got %b want %b", obs(), 8'h00);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw_stall();
    logic [7:0] want [5];
    want[0] = ex(0, 0, 0, 0, 0, 3'd0); want[1] = ex(1, 1, 0, 0, 0, 3'd0);
    want[2] = ex(1, 1, 0, 0, 0, 3'd1); want[3] = ex(0, 0, 0, 0, 0, 3'd1);
    want[4] = ex(0, 0, 0, 0, 0, 3'd0);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd3, 0, 0, 0, 0);
      else if (c < 4) drive(1, 1, 0, 3'd3, 3'd1, 0, 3'd0, 0, 0, 0, 0);
      else idle();
      #1;
      n_checks++;
      if (obs() !== want[c]) begin
        n_errors++; $display("FAIL raw_stall c%0d: got %b want %b", c, obs(), want[c]);
      end
    end
  endtask

  task automatic test_branch_raw();
    logic [7:0] want [3];
    want[0] = ex(0, 0, 0, 0, 0, 3'd0); want[1] = ex(0, 0, 0, 1, 0, 3'd0);
    want[2] = ex(0, 0, 0, 0, 0, 3'd0);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd2, 0, 0, 0, 0);
      else if (c == 1) drive(1, 0, 1, 3'd0, 3'd2, 1, 3'd6, 0, 1, 1, 0);
      else drive(1, 1, 0, 3'd6, 3'd0, 0, 3'd0, 0, 0, 0, 0);  // killed r6 write must not stall
      #1;
      n_checks++;
      if (obs() !== want[c]) begin
        n_errors++; $display("FAIL branch_raw c%0d: got %b want %b", c, obs(), want[c]);
      end
    end
  endtask

  task automatic test_dmem_stall();
    logic [7:0] want [8];
    want[0] = ex(0, 0, 0, 0, 0, 3'd0); want[1] = ex(0, 0, 1, 0, 0, 3'd0);
    want[2] = ex(0, 0, 1, 0, 0, 3'd2); want[3] = ex(0, 0, 1, 0, 0, 3'd2);
    want[4] = ex(0, 0, 1, 0, 0, 3'd2); want[5] = ex(1, 1, 0, 0, 0, 3'd2);
    want[6] = ex(1, 1, 0, 0, 0, 3'd1); want[7] = ex(0, 0, 0, 0, 0, 3'd1);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd5, 0, 0, 0, 0);
      else drive(1, 1, 0, 3'd5, 3'd0, 0, 3'd0, 0, 0, 0, c < 5);
      #1;
      n_checks++;
      if (obs() !== want[c]) begin
        n_errors++; $display("FAIL dmem_stall c%0d: got %b want %b", c, obs(), want[c]);
      end
    end
  endtask

  task automatic test_halt_drain();
    logic [7:0] want;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 0, 0, 0);
      else if (c < 4) idle();
      else drive_rand();
      if (c == 0) want = ex(0, 0, 0, 0, 0, 3'd0);
      else if (c < 4) want = ex(1, 0, 0, 0, 0, 3'd3);
      else want = ex(1, 0, 1, 0, 1, 3'd4);
      #1;
      n_checks++;
      if (obs() !== want) begin
        n_errors++; $display("FAIL halt_drain c%0d: got %b want %b", c, obs(), want);
      end
    end
  endtask

  task automatic test_spec_halt();
    logic [7:0] want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 0, 0, 0);
      else if (c == 1) drive(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0);
      else idle();
      if (c == 1) want = ex(0, 0, 0, 1, 0, 3'd3);
      else want = ex(0, 0, 0, 0, 0, 3'd0);
      #1;
      n_checks++;
      if (obs() !== want) begin
        n_errors++; $display("FAIL spec_halt c%0d: got %b want %b", c, obs(), want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] want;
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd3, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    want = ex(1, 1, 0, 0, 0, 3'd1);
    n_checks++;
    if (obs() !== want) begin
      n_errors++; $display("FAIL async_pre: got %b want %b", obs(), want);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 8'h00) begin
      n_errors++; $display("FAIL async_mid: got %b want %b", obs(), 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;  // reader of r3 still in ID: empty scoreboard means no stall
    if (obs() !== 8'h00) begin
      n_errors++; $display("FAIL async_post: got %b want %b", obs(), 8'h00);
    end
    idle();
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive_rand();
      #1;
      model_eval();
      n_checks++;
      if (obs() !== e_vec) begin
        n_errors++; $display("FAIL random c%0d: got %b want %b", c, obs(), e_vec);
      end
      model_step();
      halt_cycles = (m_mode == MHalt) ? halt_cycles + 1 : 0;
      if (halt_cycles >= 4) begin
        halt_cycles = 0;
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_branch_raw();
    test_dmem_stall();
    test_halt_drain();
    test_spec_halt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
